// File: rtl/pipe_pkg.sv
// Shared PIPE encodings: power states, the RxStatus receiver-detected code
// and the power/detect sequencer FSM states.
package pipe_pkg;

    localparam int unsigned PD_W = 2;
    localparam int unsigned RX_W = 3;

    typedef enum logic [PD_W-1:0] {
        PD_P0  = 2'd0,
        PD_P0S = 2'd1,
        PD_P1  = 2'd2,
        PD_P2  = 2'd3
    } pd_state_e;

    localparam logic [RX_W-1:0] RXSTAT_DETECTED = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PD_WAIT  = 2'd1,
        ST_DET_WAIT = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/pipe_lane_status_collector.sv
// Accumulates per-lane PhyStatus (seen) and receiver-detected results;
// only the first strobe of each lane counts until the masks are cleared.
module pipe_lane_status_collector
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4
) (
    input  logic                      pclk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [NUM_LANES-1:0]      PhyStatus,
    input  logic [RX_W*NUM_LANES-1:0] RxStatus,
    output logic [NUM_LANES-1:0]      seen,
    output logic [NUM_LANES-1:0]      detected,
    output logic                      all_seen
);

    logic [NUM_LANES-1:0] r_seen;
    logic [NUM_LANES-1:0] r_det;
    logic [NUM_LANES-1:0] w_first;
    logic [NUM_LANES-1:0] w_hit;

    // seen/detected include this cycle's strobes so completion is same-cycle
    always_comb begin
        w_hit   = '0;
        w_first = enable ? (PhyStatus & ~r_seen) : '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            w_hit[i] = (RxStatus[RX_W*i +: RX_W] == RXSTAT_DETECTED);
        end
        seen     = r_seen | w_first;
        detected = r_det | (w_first & w_hit);
        all_seen = &seen;
    end

    always_ff @(posedge pclk) begin
        if (reset || clear) begin
            r_seen <= '0;
            r_det  <= '0;
        end else if (enable) begin
            r_seen <= seen;
            r_det  <= detected;
        end
    end

endmodule

// File: rtl/pipe_power_detect_sequencer.sv
// PIPE power-state change and receiver-detect sequencer: drives PowerDown /
// TxDetectRx_Loopback and waits for PhyStatus on every lane with a timeout.
module pipe_power_detect_sequencer
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                      pclk,
    input  logic                      reset,
    input  logic                      pd_req,
    input  logic [PD_W-1:0]           pd_target,
    input  logic                      det_req,
    input  logic [NUM_LANES-1:0]      PhyStatus,
    input  logic [RX_W*NUM_LANES-1:0] RxStatus,
    output logic [3:0]                PowerDown,
    output logic                      TxDetectRx_Loopback,
    output logic                      TxElecIdle,
    output logic                      busy,
    output logic                      pd_done,
    output logic                      det_done,
    output logic                      timeout_err,
    output logic                      req_err,
    output logic [NUM_LANES-1:0]      det_lanes
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fsm_state_e           r_state;
    pd_state_e            r_pd;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_txdet;
    logic                 r_elecidle;
    logic                 r_busy;
    logic                 r_pd_done;
    logic                 r_det_done;
    logic                 r_timeout;
    logic                 r_req_err;
    logic [NUM_LANES-1:0] r_det_lanes;

    logic                 w_clear;
    logic                 w_enable;
    logic [NUM_LANES-1:0] w_seen;
    logic [NUM_LANES-1:0] w_detected;
    logic                 w_all_seen;
    pd_state_e            w_target;

    assign w_clear  = (r_state == ST_IDLE);
    assign w_enable = (r_state != ST_IDLE);
    assign w_target = pd_state_e'(pd_target);

    pipe_lane_status_collector #(
        .NUM_LANES (NUM_LANES)
    ) u_collector (
        .pclk      (pclk),
        .reset     (reset),
        .clear     (w_clear),
        .enable    (w_enable),
        .PhyStatus (PhyStatus),
        .RxStatus  (RxStatus),
        .seen      (w_seen),
        .detected  (w_detected),
        .all_seen  (w_all_seen)
    );

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pd        <= PD_P1;
            r_cnt       <= '0;
            r_txdet     <= 1'b0;
            r_elecidle  <= 1'b1;
            r_busy      <= 1'b0;
            r_pd_done   <= 1'b0;
            r_det_done  <= 1'b0;
            r_timeout   <= 1'b0;
            r_req_err   <= 1'b0;
            r_det_lanes <= '0;
        end else begin
            r_pd_done  <= 1'b0;
            r_det_done <= 1'b0;
            r_timeout  <= 1'b0;
            r_req_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    // pd_req has priority; a concurrent det_req is dropped
                    if (pd_req) begin
                        if (w_target != r_pd) begin
                            r_pd       <= w_target;
                            r_elecidle <= (w_target != PD_P0);
                            r_state    <= ST_PD_WAIT;
                            r_busy     <= 1'b1;
                        end else begin
                            r_pd_done <= 1'b1;
                        end
                    end else if (det_req) begin
                        if (r_pd == PD_P1) begin
                            r_txdet <= 1'b1;
                            r_state <= ST_DET_WAIT;
                            r_busy  <= 1'b1;
                        end else begin
                            r_req_err <= 1'b1;
                        end
                    end
                end
                ST_PD_WAIT: begin
                    if (w_all_seen) begin
                        r_pd_done <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DET_WAIT: begin
                    // completion outranks a timeout landing on the same cycle
                    if (w_all_seen) begin
                        r_txdet     <= 1'b0;
                        r_det_lanes <= w_detected & w_seen;
                        r_det_done  <= 1'b1;
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_txdet     <= 1'b0;
                        r_det_lanes <= w_detected & w_seen;
                        r_timeout   <= 1'b1;
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_txdet <= 1'b0;
                end
            endcase
        end
    end

    assign PowerDown           = {2'b00, r_pd};
    assign TxDetectRx_Loopback = r_txdet;
    assign TxElecIdle          = r_elecidle;
    assign busy                = r_busy;
    assign pd_done             = r_pd_done;
    assign det_done            = r_det_done;
    assign timeout_err         = r_timeout;
    assign req_err             = r_req_err;
    assign det_lanes           = r_det_lanes;

endmodule

// File: tb/tb_pipe_power_detect_sequencer.sv
// Directed bench for pipe_power_detect_sequencer (4 lanes, 16-cycle timeout).
module tb_pipe_power_detect_sequencer;

    logic        pclk = 1'b0;
    logic        reset;
    logic        pd_req;
    logic [1:0]  pd_target;
    logic        det_req;
    logic [3:0]  PhyStatus;
    logic [11:0] RxStatus;
    logic [3:0]  PowerDown;
    logic        TxDetectRx_Loopback;
    logic        TxElecIdle;
    logic        busy;
    logic        pd_done;
    logic        det_done;
    logic        timeout_err;
    logic        req_err;
    logic [3:0]  det_lanes;

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    pipe_power_detect_sequencer #(
        .NUM_LANES      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .pclk                (pclk),
        .reset               (reset),
        .pd_req              (pd_req),
        .pd_target           (pd_target),
        .det_req             (det_req),
        .PhyStatus           (PhyStatus),
        .RxStatus            (RxStatus),
        .PowerDown           (PowerDown),
        .TxDetectRx_Loopback (TxDetectRx_Loopback),
        .TxElecIdle          (TxElecIdle),
        .busy                (busy),
        .pd_done             (pd_done),
        .det_done            (det_done),
        .timeout_err         (timeout_err),
        .req_err             (req_err),
        .det_lanes           (det_lanes)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // {busy, txdet, elecidle, pd_done, det_done, timeout, req_err}
    function automatic logic [6:0] flags();
        return {busy, TxDetectRx_Loopback, TxElecIdle, pd_done, det_done, timeout_err, req_err};
    endfunction

    task automatic go_p1_from_idle();
        pd_req = 1'b1; pd_target = 2'd2;
        tick();
        pd_req = 1'b0; PhyStatus = 4'hF;
        tick();
        PhyStatus = 4'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pd_req = 1'b0; pd_target = 2'd0; det_req = 1'b0;
        PhyStatus = 4'h0; RxStatus = 12'h000;
        tick(); tick();
        reset = 1'b0;
        tick();
        total++;
        if (PowerDown !== 4'd2) begin
            $display("FAIL reset_powerdown: got %0d want 2", PowerDown); bad++;
        end
        total++;
        if (flags() !== 7'b0010000) begin
            $display("FAIL reset_flags: got %b want 0010000", flags()); bad++;
        end
        total++;
        if (det_lanes !== 4'b0000) begin
            $display("FAIL reset_det_lanes: got %b want 0000", det_lanes); bad++;
        end
    endtask

    task automatic test_detect();
        det_req = 1'b1;
        tick();
        det_req = 1'b0;
        total++;
        if ({busy, TxDetectRx_Loopback} !== 2'b11) begin
            $display("FAIL det_entry: got busy/txdet %b want 11", {busy, TxDetectRx_Loopback}); bad++;
        end
        repeat (4) tick();
        PhyStatus = 4'hF; RxStatus = 12'b000_000_011_011;
        tick();
        PhyStatus = 4'h0; RxStatus = 12'h000;
        total++;
        if (flags() !== 7'b0010100) begin
            $display("FAIL det_complete_flags: got %b want 0010100", flags()); bad++;
        end
        total++;
        if (det_lanes !== 4'b0011) begin
            $display("FAIL det_complete_lanes: got %b want 0011", det_lanes); bad++;
        end
        tick();
        total++;
        if (det_done !== 1'b0) begin
            $display("FAIL det_done_pulse: got %b want 0", det_done); bad++;
        end
    endtask

    task automatic test_pd_p0();
        pd_req = 1'b1; pd_target = 2'd0;
        tick();
        pd_req = 1'b0;
        total++;
        if ({PowerDown, TxElecIdle, busy} !== {4'd0, 1'b0, 1'b1}) begin
            $display("FAIL pd_entry: got pd=%0d ei=%b busy=%b want pd=0 ei=0 busy=1",
                     PowerDown, TxElecIdle, busy); bad++;
        end
        tick(); tick();
        PhyStatus = 4'b0001;
        tick();
        PhyStatus = 4'h0;
        total++;
        if ({busy, pd_done} !== 2'b10) begin
            $display("FAIL pd_partial: got busy/pd_done %b want 10", {busy, pd_done}); bad++;
        end
        tick(); tick(); tick();
        PhyStatus = 4'b1110;
        tick();
        PhyStatus = 4'h0;
        total++;
        if (flags() !== 7'b0001000 || PowerDown !== 4'd0) begin
            $display("FAIL pd_complete: got flags=%b pd=%0d want 0001000 pd=0", flags(), PowerDown); bad++;
        end
    endtask

    task automatic test_req_err();
        det_req = 1'b1;
        tick();
        det_req = 1'b0;
        total++;
        if (flags() !== 7'b0000001) begin
            $display("FAIL req_err_p0: got %b want 0000001", flags()); bad++;
        end
        tick();
        total++;
        if (flags() !== 7'b0000000) begin
            $display("FAIL req_err_pulse: got %b want 0000000", flags()); bad++;
        end
    endtask

    task automatic test_same_target();
        pd_req = 1'b1; pd_target = 2'd0;
        tick();
        pd_req = 1'b0;
        total++;
        if (flags() !== 7'b0001000 || PowerDown !== 4'd0) begin
            $display("FAIL same_target: got flags=%b pd=%0d want 0001000 pd=0", flags(), PowerDown); bad++;
        end
    endtask

    task automatic test_timeout();
        int early = 0;
        go_p1_from_idle();
        total++;
        if ({PowerDown, TxElecIdle, busy} !== {4'd2, 1'b1, 1'b0}) begin
            $display("FAIL back_to_p1: got pd=%0d ei=%b busy=%b want pd=2 ei=1 busy=0",
                     PowerDown, TxElecIdle, busy); bad++;
        end
        det_req = 1'b1;
        tick();
        det_req = 1'b0;
        PhyStatus = 4'b0111; RxStatus = 12'b000_011_000_011;
        tick();
        PhyStatus = 4'h0; RxStatus = 12'h000;
        for (int i = 2; i <= 15; i++) begin
            tick();
            if (timeout_err !== 1'b0 || det_done !== 1'b0 || busy !== 1'b1) early++;
        end
        total++;
        if (early != 0) begin
            $display("FAIL timeout_early: got %0d bad cycles want 0", early); bad++;
        end
        tick();
        total++;
        if (flags() !== 7'b0010010) begin
            $display("FAIL timeout_flags: got %b want 0010010", flags()); bad++;
        end
        total++;
        if (det_lanes !== 4'b0101) begin
            $display("FAIL timeout_lanes: got %b want 0101", det_lanes); bad++;
        end
    endtask

    task automatic test_back_to_back();
        pd_req = 1'b1; pd_target = 2'd3; det_req = 1'b1;
        tick();
        det_req = 1'b0; pd_target = 2'd0;
        total++;
        if ({PowerDown, TxDetectRx_Loopback, busy} !== {4'd3, 1'b0, 1'b1}) begin
            $display("FAIL pd_wins: got pd=%0d txdet=%b busy=%b want pd=3 txdet=0 busy=1",
                     PowerDown, TxDetectRx_Loopback, busy); bad++;
        end
        tick();
        pd_req = 1'b0;
        total++;
        if ({PowerDown, busy, pd_done} !== {4'd3, 1'b1, 1'b0}) begin
            $display("FAIL busy_ignore: got pd=%0d busy=%b done=%b want pd=3 busy=1 done=0",
                     PowerDown, busy, pd_done); bad++;
        end
        PhyStatus = 4'hF;
        tick();
        PhyStatus = 4'h0;
        total++;
        if (flags() !== 7'b0011000 || PowerDown !== 4'd3) begin
            $display("FAIL p2_done: got flags=%b pd=%0d want 0011000 pd=3", flags(), PowerDown); bad++;
        end
        tick();
        total++;
        if (flags() !== 7'b0010000) begin
            $display("FAIL no_det_after: got %b want 0010000", flags()); bad++;
        end
    endtask

    task automatic test_reset_abort();
        go_p1_from_idle();
        det_req = 1'b1;
        tick();
        det_req = 1'b0;
        total++;
        if (TxDetectRx_Loopback !== 1'b1) begin
            $display("FAIL abort_entry: got txdet=%b want 1", TxDetectRx_Loopback); bad++;
        end
        reset = 1'b1; PhyStatus = 4'hF; RxStatus = 12'b011_011_011_011;
        tick();
        reset = 1'b0; PhyStatus = 4'h0; RxStatus = 12'h000;
        total++;
        if (PowerDown !== 4'd2 || flags() !== 7'b0010000) begin
            $display("FAIL abort_reset: got pd=%0d flags=%b want pd=2 flags=0010000", PowerDown, flags()); bad++;
        end
        tick();
        total++;
        if (flags() !== 7'b0010000 || det_lanes !== 4'b0000) begin
            $display("FAIL abort_after: got flags=%b lanes=%b want 0010000 0000", flags(), det_lanes); bad++;
        end
    endtask

    task automatic test_race();
        det_req = 1'b1;
        tick();
        det_req = 1'b0;
        repeat (15) tick();
        PhyStatus = 4'hF; RxStatus = 12'b011_011_011_011;
        tick();
        PhyStatus = 4'h0; RxStatus = 12'h000;
        total++;
        if (flags() !== 7'b0010100) begin
            $display("FAIL race_flags: got %b want 0010100", flags()); bad++;
        end
        total++;
        if (det_lanes !== 4'b1111) begin
            $display("FAIL race_lanes: got %b want 1111", det_lanes); bad++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_detect();
        test_pd_p0();
        test_req_err();
        test_same_target();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        test_race();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_power_detect_sequencer.md
PIPE_POWER_DETECT_SEQUENCER -- requirements
Module: pipe_power_detect_sequencer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, meaning number of PIPE lanes sequenced together.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the maximum number of pclk cycles to wait for PhyStatus, minimum 2.
REQ-003 SHALL have port pclk, input, 1 bit, the single PIPE clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port pd_req, input, 1 bit, a one-cycle power-state change request from the LTSSM.
REQ-006 SHALL have port pd_target, input, 2 bits, the requested power state (0=P0, 1=P0s, 2=P1, 3=P2), sampled with pd_req.
REQ-007 SHALL have port det_req, input, 1 bit, a one-cycle receiver-detect request.
REQ-008 SHALL have port PhyStatus, input, NUM_LANES bits, the per-lane PHY completion strobe.
REQ-009 SHALL have port RxStatus, input, 3*NUM_LANES bits, per-lane status with lane i at bits [3i+2:3i].
REQ-010 SHALL have port PowerDown, output, 4 bits, the PIPE power state; bits [3:2] are always 0.
REQ-011 SHALL have port TxDetectRx_Loopback, output, 1 bit, the receiver-detect request to the PHY.
REQ-012 SHALL have port TxElecIdle, output, 1 bit, transmitter electrical idle.
REQ-013 SHALL have port busy, output, 1 bit, high whenever the FSM is not IDLE.
REQ-014 SHALL have ports pd_done, det_done, timeout_err and req_err, output, 1 bit each, one-cycle status pulses.
REQ-015 SHALL have port det_lanes, output, NUM_LANES bits, the per-lane receiver-detected result.

Function
REQ-016 FSM SHALL have states IDLE, PD_WAIT and DET_WAIT; all outputs SHALL be registered.
REQ-017 In IDLE with pd_req=1: if pd_target != current state, PowerDown SHALL take pd_target on the next edge, seen-mask and counter SHALL clear, and the FSM SHALL go to PD_WAIT.
REQ-018 In IDLE with pd_req=1 and pd_target equal to the current state: pd_done SHALL pulse on the next cycle, with no state change.
REQ-019 In IDLE with det_req=1 and pd_req=0: if PowerDown==P1, TxDetectRx_Loopback SHALL go to 1 on the next edge, masks and counter SHALL clear, and the FSM SHALL go to DET_WAIT; otherwise req_err SHALL pulse and the FSM SHALL stay in IDLE.
REQ-020 On simultaneous pd_req and det_req in IDLE: pd_req SHALL win and det_req SHALL be dropped silently.
REQ-021 Requests arriving while busy=1 SHALL be ignored; requesters wait for busy=0.
REQ-022 PD_WAIT: the seen-mask SHALL OR in PhyStatus each cycle; when (seen | PhyStatus) is all ones, pd_done SHALL pulse on the next cycle and the FSM SHALL return to IDLE.
REQ-023 DET_WAIT: for each lane with PhyStatus=1, the seen bit SHALL set and the detected bit SHALL set iff RxStatus lane==3'b011; only the first PhyStatus per lane SHALL count.
REQ-024 DET_WAIT completion (all lanes seen, same-cycle strobes included): on the next cycle TxDetectRx_Loopback=0, det_lanes=detected mask, det_done pulses, and the FSM returns to IDLE.
REQ-025 Counter SHALL increment every cycle in PD_WAIT/DET_WAIT; on reaching TIMEOUT_CYCLES-1 without completion, timeout_err SHALL pulse and the FSM SHALL return to IDLE.
REQ-026 On timeout in DET_WAIT: TxDetectRx_Loopback SHALL clear, det_lanes SHALL take the detected bits so far, and det_done SHALL NOT pulse.
REQ-027 On timeout in PD_WAIT: PowerDown SHALL keep the new target.
REQ-028 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-029 TxElecIdle SHALL equal (PowerDown != P0), updated on the same edge as PowerDown.
REQ-030 PhyStatus in IDLE SHALL be ignored.

Reset
REQ-031 On reset: FSM=IDLE, PowerDown=4'd2 (P1), TxElecIdle=1, TxDetectRx_Loopback=0, busy=0, det_lanes=0, all pulses 0, counter and masks 0.
REQ-032 Reset asserted mid-PD_WAIT or mid-DET_WAIT SHALL abort the operation with no done or error pulse.

Structure
REQ-033 Power-state encodings, RxStatus code 3'b011 and the FSM state enum SHALL live in shared package pipe_pkg.
REQ-034 Per-lane seen/detected mask accumulation SHALL be sub-module pipe_lane_status_collector (parameter NUM_LANES; inputs clear, enable, PhyStatus, RxStatus; outputs seen, detected, all_seen).

Verification
REQ-035 Reset, then det_req with PhyStatus=4'b1111 and RxStatus=011 on lanes 0,1 and 000 on lanes 2,3 after 5 cycles -> det_done, det_lanes=4'b0011, TxDetectRx_Loopback=0.
REQ-036 pd_req with target P0 and staggered PhyStatus (lane 0 at cycle 3, lanes 1-3 at cycle 7) -> PowerDown=0, TxElecIdle=0, pd_done one cycle after cycle 7.
REQ-037 det_req while in P0 -> req_err pulse, TxDetectRx_Loopback stays 0, busy stays 0.
REQ-038 det_req with lane 3 never strobing, TIMEOUT_CYCLES=16 -> timeout_err 16 cycles after entry, det_lanes holds lanes 0-2 result, no det_done.
REQ-039 Simultaneous pd_req(P1→P2) and det_req -> only the PD sequence runs; a pd_req while busy is ignored.
REQ-040 Reset asserted in DET_WAIT -> next cycle PowerDown=2, TxDetectRx_Loopback=0, no pulses.
